// File: rtl/scanner_fifo_tx.sv
// Gondola scanner: buffers sampled sensor bits, reports fill level on the serial link and
// streams the buffer on permit. Define SCANNER_CRC_EN to append a CRC-8 after the payload.
module scanner_fifo_tx #(
  parameter int DEPTH      = 1024,
  parameter int SAMPLE_DIV = 2,
  parameter int HDR_W      = 8,
  localparam int AW        = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go_to_standby,
  input  logic          start_scanning,
  input  logic          active,
  input  logic          sample_bit,
  input  logic          transfer_permit,
  input  logic          flush,
  input  logic          transfer_ready,
  output logic          transfer_data,
  output logic          transfer_clock,
  output logic [AW-1:0] bits_used,
  output logic [2:0]    state,
  output logic          transfer_permit_received
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
`ifdef SCANNER_CRC_EN
  localparam int CRC_LEN = 8;
`else
  localparam int CRC_LEN = 0;
`endif
  localparam int XFER_LEN = HDR_W + DEPTH + CRC_LEN;
  localparam int CW = $clog2(XFER_LEN + 1);
  localparam logic [AW-1:0] T50  = AW'(DEPTH * 50 / 100);
  localparam logic [AW-1:0] T80  = AW'(DEPTH * 80 / 100);
  localparam logic [AW-1:0] T90  = AW'(DEPTH * 90 / 100);
  localparam logic [AW-1:0] T100 = AW'(DEPTH);

  typedef enum logic [2:0] {
    S_LOWPOWER = 3'd0,
    S_STANDBY  = 3'd1,
    S_ACTIVE   = 3'd2,
    S_IDLE     = 3'd3,
    S_TRANSFER = 3'd4,
    S_FLUSH    = 3'd5
  } state_t;

  state_t           state_q;
  logic [AW-1:0]    bits_q, pay_q, bits_up_d;
  logic [PW-1:0]    wr_q, rd_q;
  logic [DW-1:0]    div_q;
  logic [HDR_W-1:0] sr_q, pend_q, new_code;
  logic             pend_vld_q, latch_q;
  logic [CW-1:0]    tx_cnt_q;
  logic             mem [DEPTH];
  logic             wr_en, new_vld, shift, tx_free, xfer_go, in_payload, pop, app_bit;
`ifdef SCANNER_CRC_EN
  logic [7:0]       crc_q;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ (((c[7] ^ b) == 1'b1) ? 8'h07 : 8'h00);
  endfunction
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign bits_up_d  = bits_q + AW'(1);
  assign wr_en      = (state_q == S_ACTIVE) && (div_q == DW'(SAMPLE_DIV - 1)) && active
                      && (bits_q < T100);
  assign new_vld    = wr_en && ((bits_up_d == T50) || (bits_up_d == T80) ||
                                (bits_up_d == T90) || (bits_up_d == T100));
  assign new_code   = (bits_up_d == T100) ? HDR_W'(4) :
                      (bits_up_d == T90)  ? HDR_W'(3) :
                      (bits_up_d == T80)  ? HDR_W'(2) : HDR_W'(1);
  assign shift      = active && transfer_ready && (tx_cnt_q != '0);
  // The serializer can take a new frame on the same edge its last bit leaves.
  assign tx_free    = (tx_cnt_q == '0) || ((tx_cnt_q == CW'(1)) && shift);
  assign xfer_go    = (state_q == S_IDLE) && (transfer_permit || latch_q) && active
                      && (tx_cnt_q == '0) && !pend_vld_q;
  assign in_payload = (state_q == S_TRANSFER) && (pay_q != '0);
  assign pop        = shift && in_payload;

  always_comb begin
    app_bit = 1'b0;
    if (in_payload) app_bit = mem[rd_q];
`ifdef SCANNER_CRC_EN
    else if (state_q == S_TRANSFER) app_bit = crc_q[7];
`endif
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_q] <= sample_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LOWPOWER;
      bits_q     <= '0;
      pay_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      div_q      <= '0;
      sr_q       <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      latch_q    <= 1'b0;
      tx_cnt_q   <= '0;
`ifdef SCANNER_CRC_EN
      crc_q      <= '0;
`endif
    end else begin
      case (state_q)
        S_LOWPOWER: if (go_to_standby) state_q <= S_STANDBY;
        S_STANDBY:  if (start_scanning) state_q <= S_ACTIVE;
        S_ACTIVE: begin
          div_q <= (div_q == DW'(SAMPLE_DIV - 1)) ? '0 : div_q + DW'(1);
          if (transfer_permit && (bits_q >= T80)) latch_q <= 1'b1;
          if (wr_en) begin
            wr_q   <= ptr_inc(wr_q);
            bits_q <= bits_up_d;
            if (bits_up_d == T100) begin
              state_q <= S_IDLE;
              div_q   <= '0;
            end
          end
        end
        S_IDLE: begin
          if (xfer_go) begin
            state_q <= S_TRANSFER;
            pay_q   <= AW'(DEPTH);
            latch_q <= 1'b0;
`ifdef SCANNER_CRC_EN
            crc_q   <= '0;
`endif
          end else if (flush && active) begin
            state_q <= S_FLUSH;
          end
        end
        S_TRANSFER: begin
          if (pop) begin
            rd_q  <= ptr_inc(rd_q);
            pay_q <= pay_q - AW'(1);
            if (bits_q != '0) bits_q <= bits_q - AW'(1);
`ifdef SCANNER_CRC_EN
            crc_q <= crc8_step(crc_q, app_bit);
          end else if (shift) begin
            crc_q <= {crc_q[6:0], 1'b0};
`endif
          end
          if ((tx_cnt_q == '0) && (bits_q == '0)) state_q <= S_LOWPOWER;
        end
        S_FLUSH: begin
          if (bits_q == '0) begin
            state_q <= S_LOWPOWER;
            rd_q    <= '0;
            wr_q    <= '0;
          end else if (active) begin
            bits_q <= bits_q - AW'(1);
          end
        end
        default: state_q <= S_LOWPOWER;
      endcase

      // Serializer: bulk header, then pending frame, then fresh frame, else shift.
      if (xfer_go) begin
        sr_q     <= HDR_W'(8'h07);
        tx_cnt_q <= CW'(XFER_LEN);
      end else if (tx_free && pend_vld_q) begin
        sr_q       <= pend_q;
        tx_cnt_q   <= CW'(HDR_W);
        pend_vld_q <= new_vld;
        if (new_vld) pend_q <= new_code;
      end else if (tx_free && new_vld) begin
        sr_q     <= new_code;
        tx_cnt_q <= CW'(HDR_W);
      end else begin
        if (new_vld) begin
          pend_q     <= new_code;
          pend_vld_q <= 1'b1;
        end
        if (shift) begin
          sr_q     <= {sr_q[HDR_W-2:0], app_bit};
          tx_cnt_q <= tx_cnt_q - CW'(1);
        end
      end
    end
  end

  assign transfer_data            = sr_q[HDR_W-1];
  assign transfer_clock           = clk & (tx_cnt_q != '0);
  assign bits_used                = bits_q;
  assign state                    = state_q;
  assign transfer_permit_received = latch_q;

endmodule
